// File: rtl/tx_packet_framer.sv
// Frames 16-bit words from prioritised producers into header/MSB/LSB[/checksum]
// byte packets and writes them into the tx FIFO, holding on wfull.
//   state | meaning
//   IDLE  | waiting for a request; grants the lowest requesting channel
//   HDR   | presenting {ch, seq, 0}
//   MSB   | presenting payload high byte
//   LSB   | presenting payload low byte
//   CSUM  | presenting header ^ MSB ^ LSB (only when CHECKSUM = 1)
`timescale 1ns/1ps
module tx_packet_framer #(
  parameter int NUM_CH   = 4,
  parameter bit CHECKSUM = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      req,
  input  logic [16*NUM_CH-1:0]   in_data,
  output logic [NUM_CH-1:0]      accept,
  output logic [7:0]             wdata,
  output logic                   winc,
  input  logic                   wfull,
  output logic                   busy,
  output logic [3:0]             seq
);

  typedef enum logic [2:0] {IDLE, HDR, MSB, LSB, CSUM} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_pay;
  logic [2:0]        r_ch;
  logic [3:0]        r_seq;
  logic [NUM_CH-1:0] r_accept;

  logic [2:0]        w_gnt_ch;
  logic [15:0]       w_gnt_pay;
  logic [NUM_CH-1:0] w_gnt_oh;
  logic              w_any_req;
  logic [7:0]        w_hdr;
  logic              w_last_byte;

  // Descending scan so the lowest requesting index wins.
  always_comb begin
    w_gnt_ch  = '0;
    w_gnt_pay = '0;
    w_gnt_oh  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_gnt_ch    = 3'(k);
        w_gnt_pay   = in_data[16*k +: 16];
        w_gnt_oh    = '0;
        w_gnt_oh[k] = 1'b1;
      end
    end
  end

  assign w_any_req = |req;
  assign w_hdr     = {r_ch, r_seq, 1'b0};

  always_comb begin
    w_state_nxt = r_state;
    wdata       = 8'h00;
    winc        = 1'b0;
    w_last_byte = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = HDR;
      end
      HDR: begin
        wdata = w_hdr;
        winc  = !wfull;
        if (!wfull) w_state_nxt = MSB;
      end
      MSB: begin
        wdata = r_pay[15:8];
        winc  = !wfull;
        if (!wfull) w_state_nxt = LSB;
      end
      LSB: begin
        wdata = r_pay[7:0];
        winc  = !wfull;
        if (!wfull) begin
          if (CHECKSUM) begin
            w_state_nxt = CSUM;
          end else begin
            w_state_nxt = IDLE;
            w_last_byte = 1'b1;
          end
        end
      end
      CSUM: begin
        wdata = w_hdr ^ r_pay[15:8] ^ r_pay[7:0];
        winc  = !wfull;
        if (!wfull) begin
          w_state_nxt = IDLE;
          w_last_byte = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pay    <= '0;
      r_ch     <= '0;
      r_seq    <= '0;
      r_accept <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_accept <= '0;
      if (r_state == IDLE && w_any_req) begin
        r_pay    <= w_gnt_pay;
        r_ch     <= w_gnt_ch;
        r_accept <= w_gnt_oh;
      end
      // Bumped on the final byte so the next header carries the new value.
      if (w_last_byte) r_seq <= r_seq + 4'd1;
    end
  end

  assign accept = r_accept;
  assign busy   = (r_state != IDLE);
  assign seq    = r_seq;

endmodule
